// File: rtl/dice_display_scanner.sv
// dice_display_scanner
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display
// that shows the state of a two-dice game.
//   digit 0   : die 2 value
//   digit 1   : die 1 value
//   digit 3:2 : decimal sum of the two dice
//   digit 7:4 : game message ("PASS", "LOSE", "roLL" or blank)
//
// A refresh counter divides CLK by REFRESH_DIV.  Each tick of that counter
// moves a 3-bit digit index to the next digit.  The game inputs are captured
// into snapshot registers once per full scan, at the tick that leaves
// digit 7, and once on the first clock after reset.  This keeps the
// displayed frame self-consistent while the game FSM changes its outputs.
//
// Parameters
//   REFRESH_DIV : clocks per digit slot (2 .. 2^20)
//   BLINK_TICKS : refresh ticks per blink half-period (blink build only)
//
// Ports
//   CLK      in   1  clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   Win      in   1  game-won flag
//   Lose     in   1  game-lost flag
//   Roll     in   1  roll-again prompt
//   DiceOut1 in   3  die 1 value (0 = not rolled, 1..6 valid, 7 = dash)
//   DiceOut2 in   3  die 2 value (same encoding)
//   Anode    out  8  active-low digit enables, Anode[i] drives digit i
//   Cathode  out  7  active-low segments {CG,CF,CE,CD,CC,CB,CA}
//
// Build option
//   DICE_DISPLAY_BLINK_EN : when defined, the "PASS"/"LOSE" message blinks
//                           with a half-period of BLINK_TICKS refresh ticks.
module dice_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 256
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Win,
  input  logic       Lose,
  input  logic       Roll,
  input  logic [2:0] DiceOut1,
  input  logic [2:0] DiceOut2,
  output logic [7:0] Anode,
  output logic [6:0] Cathode
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_A     = 7'h08;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_LC_R  = 7'h2F;
  localparam logic [6:0] G_LC_O  = 7'h23;

  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_PASS = 2'd1,
    MSG_LOSE = 2'd2,
    MSG_ROLL = 2'd3
  } msg_e;

  // Reject illegal parameter values at elaboration.
  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20) || BLINK_TICKS < 1) begin : g_param_check
    $error("dice_display_scanner: REFRESH_DIV or BLINK_TICKS out of range");
  end

  // ------------------------------------------------------------------
  // Glyph helpers
  // ------------------------------------------------------------------
  function automatic logic [6:0] dec_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // 0 is "not rolled" and shows nothing; 7 is out of range and shows a dash.
  function automatic logic [6:0] die_glyph(input logic [2:0] v);
    logic [6:0] g;
    case (v)
      3'd0:    g = G_BLANK;
      3'd7:    g = G_DASH;
      default: g = dec_glyph({1'b0, v});
    endcase
    return g;
  endfunction

  function automatic logic die_valid(input logic [2:0] v);
    return (v != 3'd0) && (v != 3'd7);
  endfunction

  // pos 3 is the leftmost message digit (digit 7), pos 0 is digit 4.
  function automatic logic [6:0] msg_glyph(input msg_e msg, input logic [1:0] pos);
    logic [6:0] g;
    g = G_BLANK;
    case (msg)
      MSG_PASS: begin
        case (pos)
          2'd3:    g = G_P;
          2'd2:    g = G_A;
          default: g = G_S;
        endcase
      end
      MSG_LOSE: begin
        case (pos)
          2'd3:    g = G_L;
          2'd2:    g = G_O;
          2'd1:    g = G_S;
          default: g = G_E;
        endcase
      end
      MSG_ROLL: begin
        case (pos)
          2'd3:    g = G_LC_R;
          2'd2:    g = G_LC_O;
          default: g = G_L;
        endcase
      end
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             first_q, first_d;
  logic             snap_win_q, snap_win_d;
  logic             snap_lose_q, snap_lose_d;
  logic             snap_roll_q, snap_roll_d;
  logic [2:0]       snap_d1_q, snap_d1_d;
  logic [2:0]       snap_d2_q, snap_d2_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;

  logic             tick;
  logic             load;
  logic             blink_blank;

  // ------------------------------------------------------------------
  // Refresh divider, digit index and input snapshot
  // ------------------------------------------------------------------
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;

    // Capture at the end of a full scan so a whole frame uses one snapshot,
    // and once right after reset so the first frame is not stale.
    load    = first_q | (tick & (idx_q == 3'd7));
    first_d = 1'b0;

    snap_win_d  = load ? Win      : snap_win_q;
    snap_lose_d = load ? Lose     : snap_lose_q;
    snap_roll_d = load ? Roll     : snap_roll_q;
    snap_d1_d   = load ? DiceOut1 : snap_d1_q;
    snap_d2_d   = load ? DiceOut2 : snap_d2_q;
  end

  // ------------------------------------------------------------------
  // Blink phase
  // ------------------------------------------------------------------
`ifdef DICE_DISPLAY_BLINK_EN
  localparam int BL_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (blink_cnt_q == BL_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
      end
    end
    // Only the end-of-game messages blink; the roll prompt stays steady.
    blink_blank = blink_phase_q & (snap_win_q | snap_lose_q);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign blink_blank = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Digit decode
  // ------------------------------------------------------------------
  logic [3:0] sum;
  logic [3:0] ones;
  logic       sum_ok;
  logic       sum_hi;
  msg_e       msg;
  logic [6:0] seg;

  always_comb begin
    sum    = {1'b0, snap_d1_q} + {1'b0, snap_d2_q};
    sum_ok = die_valid(snap_d1_q) & die_valid(snap_d2_q);
    // Valid dice sum to 2..12, so one subtraction gives the ones digit.
    sum_hi = (sum >= 4'd10);
    ones   = sum_hi ? (sum - 4'd10) : sum;

    // Win takes priority over Lose when both are asserted.
    if (snap_win_q)       msg = MSG_PASS;
    else if (snap_lose_q) msg = MSG_LOSE;
    else if (snap_roll_q) msg = MSG_ROLL;
    else                  msg = MSG_NONE;
    if (blink_blank) msg = MSG_NONE;

    seg = G_BLANK;
    case (idx_q)
      3'd0:    seg = die_glyph(snap_d2_q);
      3'd1:    seg = die_glyph(snap_d1_q);
      3'd2:    seg = sum_ok ? dec_glyph(ones) : G_BLANK;
      3'd3:    seg = (sum_ok && sum_hi) ? dec_glyph(4'd1) : G_BLANK;
      default: seg = msg_glyph(msg, idx_q[1:0]);
    endcase

    anode_d   = ~(8'd1 << idx_q);
    cathode_d = seg;
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      first_q     <= 1'b1;
      snap_win_q  <= 1'b0;
      snap_lose_q <= 1'b0;
      snap_roll_q <= 1'b0;
      snap_d1_q   <= 3'd0;
      snap_d2_q   <= 3'd0;
      anode_q     <= 8'hFF;
      cathode_q   <= G_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      snap_win_q  <= snap_win_d;
      snap_lose_q <= snap_lose_d;
      snap_roll_q <= snap_roll_d;
      snap_d1_q   <= snap_d1_d;
      snap_d2_q   <= snap_d2_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
    end
  end

  assign Anode   = anode_q;
  assign Cathode = cathode_q;

endmodule

// File: tb/tb_dice_display_scanner.sv
// Testbench for dice_display_scanner (REFRESH_DIV=4, BLINK_TICKS=2).
// A reference model derives the expected display text of every clock from
// the time elapsed since reset release and the inputs seen at each frame
// boundary; a monitor compares the DUT outputs against it.
module tb_dice_display_scanner;

  localparam int RD    = 4;
  localparam int BT    = 2;
  localparam int FRAME = 8 * RD;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       Win = 1'b0, Lose = 1'b0, Roll = 1'b0;
  logic [2:0] DiceOut1 = 3'd0, DiceOut2 = 3'd0;
  logic [7:0] Anode;
  logic [6:0] Cathode;

  dice_display_scanner #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .CLK(CLK), .reset(reset), .Win(Win), .Lose(Lose), .Roll(Roll),
    .DiceOut1(DiceOut1), .DiceOut2(DiceOut2), .Anode(Anode), .Cathode(Cathode)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  int n = 0;
  bit s_win, s_lose, s_roll;
  int s_d1, s_d2;

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;
      "3": return 7'h30;  "4": return 7'h19;  "5": return 7'h12;
      "6": return 7'h02;  "7": return 7'h78;  "8": return 7'h00;
      "9": return 7'h10;  "P": return 7'h0C;  "A": return 7'h08;
      "S": return 7'h12;  "L": return 7'h47;  "O": return 7'h40;
      "E": return 7'h06;  "r": return 7'h2F;  "o": return 7'h23;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic byte die_char(input int v);
    if (v == 0) return " ";
    if (v == 7) return "-";
    return byte'(8'h30 + v);
  endfunction

  // Character shown on digit dig of a frame built from the given snapshot.
  function automatic byte expect_char(input int dig, input bit w, input bit l,
                                      input bit r, input int d1, input int d2,
                                      input bit ph);
    string msg;
    int s;
    if (dig == 0) return die_char(d2);
    if (dig == 1) return die_char(d1);
    if (dig <= 3) begin
      if (d1 < 1 || d1 > 6 || d2 < 1 || d2 > 6) return " ";
      s = d1 + d2;
      if (dig == 2) return byte'(8'h30 + (s % 10));
      return (s >= 10) ? "1" : " ";
    end
    if (w)      msg = "PASS";
    else if (l) msg = "LOSE";
    else if (r) msg = "roLL";
    else        msg = "    ";
    if (ph && (w || l)) msg = "    ";
    return msg[7 - dig];
  endfunction

  // Model: one expected output pair per rising edge.
  always @(posedge CLK) begin : model
    exp_t e;
    int   ticks;
    int   idx;
    bit   ph;
    if (reset) begin
      n = 0;
      s_win = 0; s_lose = 0; s_roll = 0; s_d1 = 0; s_d2 = 0;
      e.an = 8'hFF;
      e.ca = 7'h7F;
    end else begin
      n++;
      ticks = (n - 1) / RD;
      idx   = ticks % 8;
`ifdef DICE_DISPLAY_BLINK_EN
      ph = ((ticks / BT) % 2) == 1;
`else
      ph = 1'b0;
`endif
      e.an = 8'hFF ^ (8'd1 << idx);
      e.ca = glyph(expect_char(idx, s_win, s_lose, s_roll, s_d1, s_d2, ph));
      if (n == 1 || (n % FRAME) == 0) begin
        s_win = Win; s_lose = Lose; s_roll = Roll;
        s_d1 = int'(DiceOut1); s_d2 = int'(DiceOut2);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (Anode !== e.an || Cathode !== e.ca) begin
        bad++;
        $display("FAIL scan n=%0d: got Anode=%h Cathode=%h, expected Anode=%h Cathode=%h",
                 n, Anode, Cathode, e.an, e.ca);
      end
    end
  end

  task automatic set_inputs(input bit w, input bit l, input bit r,
                            input int d1, input int d2);
    Win = w; Lose = l; Roll = r;
    DiceOut1 = 3'(d1); DiceOut2 = 3'(d2);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge CLK);
    #1;
  endtask

  initial begin : stim
    bit found;
    // Reset held across a few edges with inputs non-zero to prove they are ignored.
    set_inputs(1, 1, 1, 5, 5);
    step(3);
    total++;
    if (Anode !== 8'hFF || Cathode !== 7'h7F) begin
      bad++;
      $display("FAIL reset_state: got Anode=%h Cathode=%h, expected Anode=ff Cathode=7f",
               Anode, Cathode);
    end
    set_inputs(0, 0, 0, 0, 0);
    reset = 1'b0;
    step(2 * FRAME);

    // Directed frames.
    set_inputs(1, 0, 0, 3, 4); step(2 * FRAME);
    set_inputs(0, 1, 0, 6, 6); step(2 * FRAME);
    set_inputs(1, 1, 0, 6, 6); step(2 * FRAME);
    set_inputs(0, 0, 1, 5, 5); step(2 * FRAME);
    set_inputs(0, 0, 0, 7, 2); step(2 * FRAME);
    set_inputs(0, 1, 1, 0, 6); step(2 * FRAME);
    set_inputs(0, 0, 0, 1, 1); step(2 * FRAME);

    // Inputs changed mid-frame must wait for the end-of-scan capture.
    set_inputs(0, 0, 1, 4, 6); step(3 * RD + 1);
    set_inputs(1, 0, 0, 2, 3); step(2 * FRAME);

    // Randomized input changes at arbitrary points in the scan.
    for (int i = 0; i < 24; i++) begin
      set_inputs(1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step(int'($urandom_range(1, 40)));
    end

    // Asynchronous reset in the middle of digit 5.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (n > 0 && (((n - 1) / RD) % 8) == 5 && ((n - 1) % RD) == 1) found = 1;
      else step(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_wait: digit 5 slot not reached, got n=%0d, expected slot 5", n);
    end
    reset = 1'b1;
    #1;
    total++;
    if (Anode !== 8'hFF || Cathode !== 7'h7F) begin
      bad++;
      $display("FAIL async_reset: got Anode=%h Cathode=%h, expected Anode=ff Cathode=7f",
               Anode, Cathode);
    end
    step(2);
    set_inputs(1, 0, 0, 6, 5);
    reset = 1'b0;
    step(3 * FRAME);

    // Let the last expected entry be compared, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) step(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_display_scanner.md
DICE_DISPLAY_SCANNER -- requirements
Module: dice_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot; legal range 2..2^20.
REQ-002 SHALL have parameter BLINK_TICKS, default 256, refresh ticks per blink half-period; used only with DICE_DISPLAY_BLINK_EN.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Win  input  1  game-won flag from the dice game FSM.
REQ-006 SHALL have port Lose  input  1  game-lost flag from the dice game FSM.
REQ-007 SHALL have port Roll  input  1  roll-again prompt from the dice game FSM.
REQ-008 SHALL have port DiceOut1  input  3  die 1 value; 1..6 valid, 0 means not rolled.
REQ-009 SHALL have port DiceOut2  input  3  die 2 value; same encoding.
REQ-010 SHALL have port Anode  output  8  active-low digit enables; Anode[i] drives digit i.
REQ-011 SHALL have port Cathode  output  7  active-low segments {CG,CF,CE,CD,CC,CB,CA}.

Function
REQ-012 SHALL count clocks 0..REFRESH_DIV-1 and raise a one-cycle tick when the count equals REFRESH_DIV-1; the count then wraps to 0.
REQ-013 SHALL advance a 3-bit digit index modulo 8 on each tick, with 7 wrapping to 0.
REQ-014 SHALL load the snapshot registers (Win, Lose, Roll, DiceOut1, DiceOut2) on a tick taken while the index is 7, and on the first clock after reset deasserts; inputs SHALL have no effect between loads.
REQ-015 SHALL register Anode and Cathode every clock from the current index and snapshot, so both outputs lag the index by one cycle; exactly one Anode bit SHALL be low outside reset.
REQ-016 Digit 0 SHALL show DiceOut2 and digit 1 SHALL show DiceOut1; value 0 SHALL be blank (0x7F), values 1..6 SHALL be decimal glyphs, and value 7 SHALL be a dash (0x3F).
REQ-017 Digits 3:2 SHALL show the 4-bit sum of the snapshot dice in decimal: tens blank when the sum is below 10, '1' when 10..12; both digits SHALL be blank if either die is 0 or 7.
REQ-018 Digits 7:4 SHALL show "PASS" if Win; else "LOSE" if Lose; else "roLL" if Roll; else blank. Win and Lose together SHALL resolve to "PASS".
REQ-019 Glyphs (Cathode hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, P=0C, A=08, S=12, L=47, O=40, E=06, r=2F, o=23.

Reset
REQ-020 While reset is high, Anode SHALL be 0xFF and Cathode 0x7F, and the refresh count, index, snapshot and blink state SHALL be 0, independent of CLK.
REQ-021 Reset asserted mid-scan SHALL blank the display immediately; the first edge after release SHALL drive Anode=0xFE.

Configuration
REQ-022 With DICE_DISPLAY_BLINK_EN defined, a blink phase SHALL toggle every BLINK_TICKS ticks, and digits 7:4 SHALL be blank during phase 1 when snapshot Win or Lose is set; "roLL" and digits 3:0 SHALL never blink.
REQ-023 Without DICE_DISPLAY_BLINK_EN, no blink counter SHALL exist and message digits SHALL be steady.

Verification (REFRESH_DIV=4, BLINK_TICKS=2)
REQ-024 Reset release, all inputs 0 -> Anode cycles FE,FD,...,7F every 4 clocks, with Cathode=7F on every digit.
REQ-025 DiceOut1=3, DiceOut2=4, Win=1 held one frame -> digit0=19, digit1=30, digit2=78, digit3=7F, digits7..4 = 0C,08,12,12 on the following frame.
REQ-026 DiceOut1=6, DiceOut2=6, Lose=1 -> digits3:2 = 79,24 and digits7..4 = 47,40,12,06; with Win also 1 -> "PASS".
REQ-027 Inputs changed while index is 3 -> display unchanged until the tick at index 7; new values appear from digit 0.
REQ-028 Reset pulsed while index is 5 -> Anode=FF asynchronously; after release, Anode=FE one edge later.
REQ-029 BLINK_EN build with Win=1 -> digits 7:4 alternate "PASS" and blank every 2 ticks while digits 3:0 stay lit; non-BLINK build keeps them steady.
